// File: rtl/conv_window_addr_gen.sv
// KxK sliding-window address generator for the feature-map SRAM.
// Emits one pixel address per accepted transfer, ordered out-row/out-col/kernel-row/kernel-col.
module conv_window_addr_gen #(
    parameter int FM_W       = 14,
    parameter int FM_H       = 14,
    parameter int K          = 3,
    parameter int STRIDE     = 1,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_valid_o,
    input  logic                  addr_ready_i,
    output logic [7:0]            tap_idx_o,
    output logic                  win_last_o,
    output logic                  frame_done_o,
    output logic                  busy_o
);

    localparam int OUT_W = (FM_W - K) / STRIDE + 1;
    localparam int OUT_H = (FM_H - K) / STRIDE + 1;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] K_LAST    = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] OCOL_LAST = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] OROW_LAST = CNT_W'(OUT_H - 1);

    // All address steps are elaboration-time constants, so the datapath needs only adders.
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP      = ADDR_WIDTH'(FM_W - K + 1);
    localparam logic [ADDR_WIDTH-1:0] COL_STEP      = ADDR_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] ROW_BASE_STEP = ADDR_WIDTH'(STRIDE * FM_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] kc, kc_nxt;
    logic [CNT_W-1:0] kr, kr_nxt;
    logic [CNT_W-1:0] ocol, ocol_nxt;
    logic [CNT_W-1:0] orow, orow_nxt;

    logic [ADDR_WIDTH-1:0] row_base, row_base_nxt;
    logic [ADDR_WIDTH-1:0] col_base, col_base_nxt;
    logic [ADDR_WIDTH-1:0] addr_p0, addr_nxt;
    logic [7:0]            tap_p0, tap_nxt;
    logic                  vld_p0;
    logic                  xfer;

    assign vld_p0 = (state == S_RUN);
    assign xfer   = vld_p0 && addr_ready_i;

    always_comb begin
        state_nxt    = state;
        kc_nxt       = kc;
        kr_nxt       = kr;
        ocol_nxt     = ocol;
        orow_nxt     = orow;
        row_base_nxt = row_base;
        col_base_nxt = col_base;
        addr_nxt     = addr_p0;
        tap_nxt      = tap_p0;

        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt    = S_RUN;
                    kc_nxt       = '0;
                    kr_nxt       = '0;
                    ocol_nxt     = '0;
                    orow_nxt     = '0;
                    row_base_nxt = '0;
                    col_base_nxt = '0;
                    addr_nxt     = '0;
                    tap_nxt      = '0;
                end
            end

            S_RUN: begin
                if (xfer) begin
                    if (kc != K_LAST) begin
                        kc_nxt   = kc + 1'b1;
                        addr_nxt = addr_p0 + 1'b1;
                        tap_nxt  = tap_p0 + 1'b1;
                    end else begin
                        kc_nxt = '0;
                        if (kr != K_LAST) begin
                            kr_nxt   = kr + 1'b1;
                            addr_nxt = addr_p0 + ROW_STEP;
                            tap_nxt  = tap_p0 + 1'b1;
                        end else begin
                            // Window finished: next address is the updated window origin.
                            kr_nxt  = '0;
                            tap_nxt = '0;
                            if (ocol != OCOL_LAST) begin
                                ocol_nxt     = ocol + 1'b1;
                                col_base_nxt = col_base + COL_STEP;
                                addr_nxt     = row_base + col_base_nxt;
                            end else begin
                                ocol_nxt     = '0;
                                col_base_nxt = '0;
                                if (orow != OROW_LAST) begin
                                    orow_nxt     = orow + 1'b1;
                                    row_base_nxt = row_base + ROW_BASE_STEP;
                                    addr_nxt     = row_base_nxt;
                                end else begin
                                    orow_nxt     = '0;
                                    row_base_nxt = '0;
                                    addr_nxt     = '0;
                                    state_nxt    = S_DONE;
                                end
                            end
                        end
                    end
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Stage p0: registered address/tap presented to the operand loader
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            kc       <= '0;
            kr       <= '0;
            ocol     <= '0;
            orow     <= '0;
            row_base <= '0;
            col_base <= '0;
            addr_p0  <= '0;
            tap_p0   <= '0;
        end else begin
            state    <= state_nxt;
            kc       <= kc_nxt;
            kr       <= kr_nxt;
            ocol     <= ocol_nxt;
            orow     <= orow_nxt;
            row_base <= row_base_nxt;
            col_base <= col_base_nxt;
            addr_p0  <= addr_nxt;
            tap_p0   <= tap_nxt;
        end
    end

    assign addr_o       = addr_p0;
    assign addr_valid_o = vld_p0;
    assign tap_idx_o    = tap_p0;
    assign win_last_o   = vld_p0 && (kc == K_LAST) && (kr == K_LAST);
    assign frame_done_o = (state == S_DONE);
    assign busy_o       = (state != S_IDLE);

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Scoreboard bench: three generator configurations (4x4 S1, 5x5 S2, 14x14 S1) run in parallel,
// each checked against a nested-loop window model.
module tb_conv_window_addr_gen;

    typedef struct {
        int addr;
        int tap;
        int wl;
        int fl;
    } exp_t;

    logic clk;
    int   tchecks;
    int   tfails;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int FW = (g == 0) ? 4 : (g == 1) ? 5 : 14;
        localparam int FH = FW;
        localparam int KK = 3;
        localparam int ST = (g == 1) ? 2 : 1;
        localparam int OW = (FW - KK) / ST + 1;
        localparam int OH = (FH - KK) / ST + 1;

        logic       rst_n;
        logic       start;
        logic       ready;
        logic [7:0] addr;
        logic       valid;
        logic [7:0] tap;
        logic       wl;
        logic       done;
        logic       busy;

        exp_t q[$];
        int   checks = 0;
        int   fails = 0;
        int   popped = 0;
        int   lat_req = 0;
        int   lat_ack = 0;
        bit   rst_s = 1'b0;
        bit   fin = 1'b0;
        bit   tmo = 1'b0;

        conv_window_addr_gen #(
            .FM_W(FW), .FM_H(FH), .K(KK), .STRIDE(ST), .ADDR_WIDTH(8)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .start_i(start),
            .addr_o(addr),
            .addr_valid_o(valid),
            .addr_ready_i(ready),
            .tap_idx_o(tap),
            .win_last_o(wl),
            .frame_done_o(done),
            .busy_o(busy)
        );

        task automatic chk(input string nm, input int act, input int exp);
            checks++;
            if (act != exp) begin
                fails++;
                $display("FAIL cfg%0d %s: got %0d expected %0d at %0t", g, nm, act, exp, $time);
            end
        endtask

        // Reference: every tap of every window straight from the address formula.
        task automatic push_frame();
            exp_t e;
            for (int orow = 0; orow < OH; orow++)
                for (int ocol = 0; ocol < OW; ocol++)
                    for (int kr = 0; kr < KK; kr++)
                        for (int kc = 0; kc < KK; kc++) begin
                            e.addr = (orow * ST + kr) * FW + ocol * ST + kc;
                            e.tap  = kr * KK + kc;
                            e.wl   = (kr == KK - 1 && kc == KK - 1) ? 1 : 0;
                            e.fl   = (orow == OH - 1 && ocol == OW - 1 && e.wl == 1) ? 1 : 0;
                            q.push_back(e);
                        end
        endtask

        task automatic cyc(output bit xf);
            @(negedge clk);
            xf = valid && ready;
            @(posedge clk);
            #1;
        endtask

        // mode 0: ready=1, 1: random ready, 2: reset after 7th transfer, 3: stray start pulses
        task automatic run_frame(input int mode);
            int nx;
            int budget;
            int total;
            bit xf;
            total = OW * OH * KK * KK;
            push_frame();
            start = 1'b1;
            ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc(xf);
            start = 1'b0;
            lat_req++;
            nx = 0;
            budget = 0;
            while (nx < total && budget < 20000) begin
                if (mode == 1) ready = 1'($urandom_range(0, 1));
                start = (mode == 3 && nx == 10) ? 1'b1 : 1'b0;
                cyc(xf);
                budget++;
                if (xf) nx++;
                if (mode == 2 && nx == 7) begin
                    rst_n = 1'b0;
                    ready = 1'b0;
                    start = 1'b0;
                    cyc(xf);
                    q.delete();
                    rst_n = 1'b1;
                    ready = 1'b1;
                    repeat (2) cyc(xf);
                    return;
                end
            end
            start = 1'b0;
            if (nx < total) tmo = 1'b1;
            if (mode == 3) begin
                start = 1'b1;
                cyc(xf);
                start = 1'b0;
            end
            repeat (3) cyc(xf);
        endtask

        initial begin
            bit xf;
            rst_n = 1'b0;
            start = 1'b0;
            ready = 1'b0;
            repeat (3) cyc(xf);
            rst_n = 1'b1;
            cyc(xf);
            if (g == 0) begin
                run_frame(0);
                run_frame(1);
                run_frame(2);
                run_frame(0);
                run_frame(3);
            end else begin
                run_frame(0);
            end
            fin = 1'b1;
        end

        initial forever begin
            @(posedge clk);
            rst_s = rst_n;
        end

        initial begin
            bit due;
            bit cur;
            bit pv;
            bit pr;
            int paddr;
            int ptap;
            due = 0;
            pv = 0;
            pr = 0;
            paddr = 0;
            ptap = 0;
            forever begin
                @(negedge clk);
                if (!rst_s) begin
                    chk("reset_valid", valid, 0);
                    chk("reset_busy", busy, 0);
                    chk("reset_frame_done", done, 0);
                    chk("reset_addr", addr, 0);
                    chk("reset_tap", tap, 0);
                    chk("reset_win_last", wl, 0);
                    due = 0;
                    pv = 0;
                end else begin
                    cur = due;
                    due = 0;
                    chk("frame_done", done, cur);
                    if (cur) begin
                        chk("done_busy", busy, 1);
                        chk("done_valid", valid, 0);
                    end else if (q.size() == 0) begin
                        chk("idle_valid", valid, 0);
                        chk("idle_busy", busy, 0);
                    end
                    if (lat_req != lat_ack) begin
                        lat_ack = lat_req;
                        chk("start_latency_valid", valid, 1);
                    end
                    if (pv && !pr && valid) begin
                        chk("stall_addr_stable", addr, paddr);
                        chk("stall_tap_stable", tap, ptap);
                    end
                    if (valid && q.size() > 0) begin
                        chk("addr", addr, q[0].addr);
                        chk("tap_idx", tap, q[0].tap);
                        chk("win_last", wl, q[0].wl);
                        if (ready) begin
                            if (q[0].fl != 0) due = 1;
                            void'(q.pop_front());
                            popped++;
                        end
                    end
                    pv = valid;
                    pr = ready;
                    paddr = addr;
                    ptap = tap;
                end
            end
        end
    end

    task automatic tchk(input string nm, input int act, input int exp);
        tchecks++;
        if (act != exp) begin
            tfails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        int n;
        tchecks = 0;
        tfails = 0;
        n = 0;
        while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        tchk("all_configs_finished", int'(cfg[0].fin && cfg[1].fin && cfg[2].fin), 1);
        tchk("cfg0_transfers", cfg[0].popped, 4 * 36 + 7);
        tchk("cfg1_transfers", cfg[1].popped, 36);
        tchk("cfg2_transfers", cfg[2].popped, 1296);
        tchk("cfg0_no_timeout", int'(cfg[0].tmo), 0);
        tchk("cfg1_no_timeout", int'(cfg[1].tmo), 0);
        tchk("cfg2_no_timeout", int'(cfg[2].tmo), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 tchecks + cfg[0].checks + cfg[1].checks + cfg[2].checks,
                 tfails + cfg[0].fails + cfg[1].fails + cfg[2].fails);
        $finish;
    end

endmodule
